// File: rtl/dcs_receiver_if.sv
// Symbol-stream and result bundle between a DCS coded-symbol source and the receiver.
// The master drives start/symbols; the slave (receiver) returns handshake, status and results.
interface dcs_receiver_if #(
    parameter int INFO_BITS = 32
);
    logic                 start;
    logic                 sym_valid;
    logic [1:0]           sym_in;
    logic                 sym_ready;
    logic                 busy;
    logic                 done;
    logic [INFO_BITS-1:0] data_out;
    logic [15:0]          crc_rx;
    logic                 crc_ok;

    modport master (
        output start, sym_valid, sym_in,
        input  sym_ready, busy, done, data_out, crc_rx, crc_ok
    );

    modport slave (
        input  start, sym_valid, sym_in,
        output sym_ready, busy, done, data_out, crc_rx, crc_ok
    );
endinterface

// File: rtl/dcs_receiver.sv
// DCS receiver: hard-decision Viterbi decoder for the rate-1/2 K=5 (G0=11111, G1=11011) zero-tail code,
// followed by a serial CRC-16 (0x8005, init 0xFFFF) check of the decoded payload.
module dcs_receiver #(
    parameter int INFO_BITS = 32,
    parameter int TAIL_BITS = 4,
    parameter int PM_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    dcs_receiver_if.slave bus
);
    localparam int CRC_W   = 16;
    localparam int FRAME_W = INFO_BITS + CRC_W;
    localparam int N_PAIRS = FRAME_W + TAIL_BITS;
    localparam int CNT_W   = $clog2(N_PAIRS);
    localparam int N_ST    = 16;

    typedef enum logic [2:0] {S_IDLE, S_ACS, S_TRACE, S_CRC, S_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_tb;
    logic [FRAME_W-1:0] r_frame;
    logic [CRC_W-1:0]   r_crc;
    logic [PM_W-1:0]    r_pm  [N_ST];
    logic [N_ST-1:0]    r_dec [N_PAIRS];

    logic               w_accept;
    logic [PM_W:0]      w_sel     [N_ST];
    logic [PM_W-1:0]    w_pm_next [N_ST];
    logic [N_ST-1:0]    w_dec;
    logic [CNT_W-1:0]   w_crc_idx;
    logic               w_crc_bit;
    logic               w_crc_fb;
    logic [CRC_W-1:0]   w_crc_next;

    function automatic logic [1:0] branch_metric(input logic [3:0] p, input logic u, input logic [1:0] sym);
        logic c0, c1;
        c0 = u ^ p[3] ^ p[2] ^ p[1] ^ p[0];
        c1 = u ^ p[3] ^ p[1] ^ p[0];
        return {1'b0, sym[1] ^ c1} + {1'b0, sym[0] ^ c0};
    endfunction

    // Returns {decision, survivor metric}; on a tie the x=0 predecessor wins.
    function automatic logic [PM_W:0] acs_select(input logic [3:0] n, input logic [PM_W-1:0] pm0,
                                                 input logic [PM_W-1:0] pm1, input logic [1:0] sym);
        logic [PM_W-1:0] m0, m1;
        m0 = pm0 + PM_W'(branch_metric({n[2:0], 1'b0}, n[3], sym));
        m1 = pm1 + PM_W'(branch_metric({n[2:0], 1'b1}, n[3], sym));
        return (m1 < m0) ? {1'b1, m1} : {1'b0, m0};
    endfunction

    assign w_accept = (r_state == S_ACS) && bus.sym_valid && bus.sym_ready;

    // NOTE: every always_comb output is fully assigned on each pass (here by complete loops), so no latch is inferred.
    always_comb begin
        for (int n = 0; n < N_ST; n++) begin
            w_sel[n]     = acs_select(4'(n), r_pm[4'(2 * n)], r_pm[4'(2 * n + 1)], bus.sym_in);
            w_dec[n]     = w_sel[n][PM_W];
            w_pm_next[n] = w_sel[n][PM_W-1:0];
        end
    end

    // Payload occupies r_frame[FRAME_W-1:CRC_W]; the CRC walks it MSB first as r_cnt counts down.
    assign w_crc_idx  = r_cnt + CNT_W'(CRC_W);
    assign w_crc_bit  = r_frame[w_crc_idx];
    assign w_crc_fb   = w_crc_bit ^ r_crc[CRC_W-1];
    assign w_crc_next = {r_crc[CRC_W-2:0], w_crc_fb} ^ (w_crc_fb ? 16'h8004 : 16'h0000);

    // NOTE: metrics and decision rows have no reset; start re-initialises the metrics and each row is written before trace reads it.
    always_ff @(posedge clk) begin
        if (bus.start) begin
            for (int s = 0; s < N_ST; s++) begin
                r_pm[s] <= (s == 0) ? '0 : PM_W'(8'h40);
            end
        end else if (w_accept) begin
            for (int s = 0; s < N_ST; s++) begin
                r_pm[s] <= w_pm_next[s];
            end
            r_dec[r_cnt] <= w_dec;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_tb          <= '0;
            r_frame       <= '0;
            r_crc         <= '0;
            bus.sym_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.data_out  <= '0;
            bus.crc_rx    <= '0;
            bus.crc_ok    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.start) begin
                r_state       <= S_ACS;
                r_cnt         <= '0;
                bus.sym_ready <= 1'b1;
                bus.busy      <= 1'b1;
            end else begin
                case (r_state)
                    S_ACS: begin
                        if (w_accept) begin
                            if (r_cnt == CNT_W'(N_PAIRS - 1)) begin
                                r_state       <= S_TRACE;
                                r_tb          <= '0;
                                bus.sym_ready <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_TRACE: begin
                        // Tail bits enter first and are shifted out the bottom before the frame completes.
                        r_frame <= {r_tb[3], r_frame[FRAME_W-1:1]};
                        r_tb    <= {r_tb[2:0], r_dec[r_cnt][r_tb]};
                        if (r_cnt == '0) begin
                            r_state <= S_CRC;
                            r_cnt   <= CNT_W'(INFO_BITS - 1);
                            r_crc   <= '1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_CRC: begin
                        r_crc <= w_crc_next;
                        if (r_cnt == '0) begin
                            r_state      <= S_DONE;
                            bus.done     <= 1'b1;
                            bus.busy     <= 1'b0;
                            bus.data_out <= r_frame[FRAME_W-1:CRC_W];
                            bus.crc_rx   <= r_frame[CRC_W-1:0];
                            bus.crc_ok   <= (w_crc_next == r_frame[CRC_W-1:0]);
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dcs_receiver.sv
// Directed bench for dcs_receiver: encodes frames with a reference CRC/convolutional encoder,
// streams them in, and checks decode results, latency, handshake, reset and restart behaviour.
module tb_dcs_receiver;
    logic clk = 1'b0;
    logic reset;

    dcs_receiver_if #(.INFO_BITS(32)) bus ();

    dcs_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  tx_pairs [52];
    logic [15:0] model_crc;

    // Textbook shift-and-xor form of CRC-16 0x8005, init 0xFFFF, MSB first.
    function automatic logic [15:0] crc16_model(input logic [31:0] d);
        logic [15:0] r;
        logic        top;
        r = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            top = r[15] ^ d[i];
            r   = r << 1;
            if (top) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    task automatic build_frame(input logic [31:0] data, input logic [15:0] crc_xor);
        logic [51:0] bits;
        logic [3:0]  p;
        logic        u, c0, c1;
        model_crc = crc16_model(data);
        bits = {data, model_crc ^ crc_xor, 4'b0000};
        p = 4'd0;
        for (int t = 0; t < 52; t++) begin
            u  = bits[51 - t];
            c0 = u ^ p[3] ^ p[2] ^ p[1] ^ p[0];
            c1 = u ^ p[3] ^ p[1] ^ p[0];
            tx_pairs[t] = {c1, c0};
            p = {u, p[3:1]};
        end
    endtask

    task automatic do_start(input bit with_pair);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.sym_valid = with_pair;
        bus.sym_in    = 2'b11;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.sym_valid = 1'b0;
    endtask

    // Drives pairs 0..n_pairs-1; a pair counts as taken when sym_ready is high at the driving edge.
    task automatic drive_pairs(input bit gappy, input int n_pairs);
        int i     = 0;
        int stall = 0;
        bit gap   = 1'b0;
        while (i < n_pairs) begin
            @(negedge clk);
            if (gap) begin
                bus.sym_valid = 1'b0;
                gap = 1'b0;
            end else begin
                bus.sym_valid = 1'b1;
                bus.sym_in    = tx_pairs[i];
                gap = gappy;
                if (bus.sym_ready) begin
                    i++;
                    stall = 0;
                end else begin
                    stall++;
                    if (stall > 50) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sym_ready_timeout at pair %0d: got sym_ready=0, want 1", i);
                        break;
                    end
                end
            end
        end
    endtask

    // Observes 100 cycles after the last pair: latency of first done, done count, sym_ready leakage.
    task automatic wait_done(output int lat, output int n_done, output bit ready_bad);
        lat = -1;
        n_done = 0;
        ready_bad = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            bus.sym_valid = 1'b0;
            if (bus.sym_ready) ready_bad = 1'b1;
            if (bus.done) begin
                n_done++;
                if (lat < 0) lat = c;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_in = 2'b00;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.sym_ready, bus.busy, bus.done, bus.crc_ok, bus.crc_rx, bus.data_out} !== 52'd0) begin
            n_err++;
            $display("FAIL reset_held outputs got=%h want=0",
                     {bus.sym_ready, bus.busy, bus.done, bus.crc_ok, bus.crc_rx, bus.data_out});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.sym_ready, bus.busy, bus.done, bus.crc_ok, bus.crc_rx, bus.data_out} !== 52'd0) begin
            n_err++;
            $display("FAIL reset_idle outputs got=%h want=0",
                     {bus.sym_ready, bus.busy, bus.done, bus.crc_ok, bus.crc_rx, bus.data_out});
        end
    endtask

    task automatic test_zero_frame();
        int lat, nd;
        bit rb;
        build_frame(32'h0000_0000, 16'h0000);
        do_start(1'b1);
        drive_pairs(1'b0, 52);
        wait_done(lat, nd, rb);
        n_vec++; if (lat !== 85) begin n_err++; $display("FAIL zero_latency got=%0d want=85", lat); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL zero_done_count got=%0d want=1", nd); end
        n_vec++; if (bus.data_out !== 32'h0) begin n_err++; $display("FAIL zero_data got=%h want=%h", bus.data_out, 32'h0); end
        n_vec++; if (bus.crc_rx !== model_crc) begin n_err++; $display("FAIL zero_crc_rx got=%h want=%h", bus.crc_rx, model_crc); end
        n_vec++; if (bus.crc_ok !== 1'b1) begin n_err++; $display("FAIL zero_crc_ok got=%b want=1", bus.crc_ok); end
        n_vec++; if (rb !== 1'b0) begin n_err++; $display("FAIL zero_ready_after got=%b want=0", rb); end
    endtask

    task automatic test_gaps_and_errors();
        int lat, nd;
        bit rb;
        build_frame(32'hDEAD_BEEF, 16'h0000);
        tx_pairs[5]  = tx_pairs[5]  ^ 2'b01;
        tx_pairs[30] = tx_pairs[30] ^ 2'b10;
        do_start(1'b0);
        drive_pairs(1'b1, 52);
        wait_done(lat, nd, rb);
        n_vec++; if (lat !== 85) begin n_err++; $display("FAIL gap_latency got=%0d want=85", lat); end
        n_vec++; if (bus.data_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL gap_data got=%h want=%h", bus.data_out, 32'hDEAD_BEEF); end
        n_vec++; if (bus.crc_rx !== model_crc) begin n_err++; $display("FAIL gap_crc_rx got=%h want=%h", bus.crc_rx, model_crc); end
        n_vec++; if (bus.crc_ok !== 1'b1) begin n_err++; $display("FAIL gap_crc_ok got=%b want=1", bus.crc_ok); end
    endtask

    task automatic test_bad_crc();
        int lat, nd;
        bit rb;
        build_frame(32'h1234_5678, 16'h0001);
        do_start(1'b0);
        drive_pairs(1'b0, 52);
        wait_done(lat, nd, rb);
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL badcrc_done_count got=%0d want=1", nd); end
        n_vec++; if (bus.data_out !== 32'h1234_5678) begin n_err++; $display("FAIL badcrc_data got=%h want=%h", bus.data_out, 32'h1234_5678); end
        n_vec++; if (bus.crc_rx !== (model_crc ^ 16'h0001)) begin n_err++; $display("FAIL badcrc_crc_rx got=%h want=%h", bus.crc_rx, model_crc ^ 16'h0001); end
        n_vec++; if (bus.crc_ok !== 1'b0) begin n_err++; $display("FAIL badcrc_crc_ok got=%b want=0", bus.crc_ok); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, nd;
        bit rb;
        build_frame(32'hA5A5_A5A5, 16'h0000);
        do_start(1'b0);
        drive_pairs(1'b0, 20);
        @(negedge clk);
        bus.sym_valid = 1'b0;
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midreset_busy_before got=%b want=1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.sym_ready, bus.busy, bus.done, bus.crc_ok, bus.crc_rx, bus.data_out} !== 52'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {bus.sym_ready, bus.busy, bus.done, bus.crc_ok, bus.crc_rx, bus.data_out});
        end
        @(negedge clk);
        reset = 1'b0;
        do_start(1'b0);
        drive_pairs(1'b0, 52);
        wait_done(lat, nd, rb);
        n_vec++; if (bus.data_out !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL postreset_data got=%h want=%h", bus.data_out, 32'hA5A5_A5A5); end
        n_vec++; if (bus.crc_ok !== 1'b1) begin n_err++; $display("FAIL postreset_crc_ok got=%b want=1", bus.crc_ok); end
    endtask

    task automatic test_restart();
        int lat, nd;
        bit rb;
        build_frame(32'h1111_1111, 16'h0000);
        do_start(1'b0);
        drive_pairs(1'b0, 40);
        do_start(1'b0);
        n_vec++; if (bus.data_out !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL restart_hold_data got=%h want=%h", bus.data_out, 32'hA5A5_A5A5); end
        build_frame(32'hCAFE_F00D, 16'h0000);
        drive_pairs(1'b0, 52);
        wait_done(lat, nd, rb);
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL restart_done_count got=%0d want=1", nd); end
        n_vec++; if (lat !== 85) begin n_err++; $display("FAIL restart_latency got=%0d want=85", lat); end
        n_vec++; if (bus.data_out !== 32'hCAFE_F00D) begin n_err++; $display("FAIL restart_data got=%h want=%h", bus.data_out, 32'hCAFE_F00D); end
        n_vec++; if (bus.crc_ok !== 1'b1) begin n_err++; $display("FAIL restart_crc_ok got=%b want=1", bus.crc_ok); end
    endtask

    task automatic test_inverted();
        int lat, nd;
        bit rb;
        build_frame(32'h0F0F_0F0F, 16'h0000);
        for (int t = 0; t < 52; t++) tx_pairs[t] = ~tx_pairs[t];
        do_start(1'b0);
        drive_pairs(1'b0, 52);
        wait_done(lat, nd, rb);
        n_vec++; if (lat !== 85) begin n_err++; $display("FAIL inv_latency got=%0d want=85", lat); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL inv_done_count got=%0d want=1", nd); end
        n_vec++; if (bus.crc_ok !== 1'b0) begin n_err++; $display("FAIL inv_crc_ok got=%b want=0", bus.crc_ok); end
        n_vec++; if (rb !== 1'b0) begin n_err++; $display("FAIL inv_ready_after got=%b want=0", rb); end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_gaps_and_errors();
        test_bad_crc();
        test_reset_mid_frame();
        test_restart();
        test_inverted();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
